// File: rtl/traffic_phase_sequencer_pkg.sv
// Shared phase encoding, default phase durations and phase-order helper
// for traffic_phase_sequencer.
package traffic_phase_sequencer_pkg;

    typedef enum logic [1:0] {
        ALL_RED = 2'd0,
        GREEN   = 2'd1,
        YELLOW  = 2'd2,
        RED     = 2'd3
    } phase_t;

    localparam int DEF_GREEN_T     = 8;
    localparam int DEF_YELLOW_T    = 3;
    localparam int DEF_RED_T       = 6;
    localparam int DEF_MIN_GREEN_T = 2;
    localparam int DEF_CNT_W       = 4;

    // ALL_RED is only ever left once; the steady cycle is GREEN/YELLOW/RED.
    function automatic phase_t next_phase(input phase_t p);
        case (p)
            ALL_RED: next_phase = GREEN;
            GREEN:   next_phase = YELLOW;
            YELLOW:  next_phase = RED;
            default: next_phase = GREEN;
        endcase
    endfunction

endpackage

// File: rtl/traffic_phase_sequencer_sync_edge_detect.sv
// Two-flop synchroniser with a one-cycle rising-edge pulse on the synchronised level.
module sync_edge_detect
    import traffic_phase_sequencer_pkg::*;
#(
    parameter logic HIST_INIT = 1'b1
) (
    input  logic clock,
    input  logic reset_n,
    input  logic raw,
    output logic rise
);

    logic       meta;
    logic       sync;
    logic       hist;
    logic [1:0] fill;

    // History is frozen until the chain has flushed its reset zeros, so a
    // level that is already high at reset release never looks like an edge.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            meta <= 1'b0;
            sync <= 1'b0;
            hist <= HIST_INIT;
            fill <= 2'b00;
        end else begin
            meta <= raw;
            sync <= meta;
            fill <= {fill[0], 1'b1};
            if (fill[1]) hist <= sync;
        end
    end

    assign rise = sync & ~hist;

endmodule

// File: rtl/traffic_phase_sequencer.sv
// Traffic light phase sequencer: ALL_RED -> GREEN -> YELLOW -> RED -> GREEN ...
// Define PED_REQUEST_EN to let a pedestrian request cut GREEN short and gate walk.
module traffic_phase_sequencer
    import traffic_phase_sequencer_pkg::*;
#(
    parameter int GREEN_T     = DEF_GREEN_T,
    parameter int YELLOW_T    = DEF_YELLOW_T,
    parameter int RED_T       = DEF_RED_T,
    parameter int MIN_GREEN_T = DEF_MIN_GREEN_T,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             tick_in,
    input  logic             blink_in,
    input  logic             ped_req,
    output logic             light_g,
    output logic             light_y,
    output logic             light_r,
    output logic             walk,
    output logic [CNT_W-1:0] remaining,
    output logic             phase_tick
);

`ifdef PED_REQUEST_EN
    localparam bit PED_EN = 1'b1;
`else
    localparam bit PED_EN = 1'b0;
`endif

    logic tick;
    logic ped_rise;
    logic blink_meta;
    logic blink_sync;

    sync_edge_detect #(.HIST_INIT(1'b1)) u_tick_sync (
        .clock   (clock),
        .reset_n (reset_n),
        .raw     (tick_in),
        .rise    (tick)
    );

    sync_edge_detect #(.HIST_INIT(1'b1)) u_ped_sync (
        .clock   (clock),
        .reset_n (reset_n),
        .raw     (ped_req),
        .rise    (ped_rise)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            blink_meta <= 1'b0;
            blink_sync <= 1'b0;
        end else begin
            blink_meta <= blink_in;
            blink_sync <= blink_meta;
        end
    end

    function automatic logic [CNT_W-1:0] phase_load(input phase_t p);
        case (p)
            GREEN:   phase_load = CNT_W'(GREEN_T - 1);
            YELLOW:  phase_load = CNT_W'(YELLOW_T - 1);
            RED:     phase_load = CNT_W'(RED_T - 1);
            default: phase_load = '0;
        endcase
    endfunction

    phase_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             req_q, req_d;
    logic             walk_q, walk_d;
    logic             pt_q, pt_d;
    logic             min_green_met;
    logic             cut;

    // Ticks spent in GREEN including the current one is GREEN_T - cnt.
    assign min_green_met = (int'(cnt_q) + MIN_GREEN_T) <= GREEN_T;
    assign cut           = PED_EN && (state_q == GREEN) && req_q && min_green_met;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ALL_RED;
            cnt_q   <= '0;
            req_q   <= 1'b0;
            walk_q  <= 1'b0;
            pt_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            walk_q  <= walk_d;
            pt_q    <= pt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        walk_d  = walk_q;
        pt_d    = 1'b0;
        if (tick) begin
            if ((cnt_q == '0) || cut) begin
                state_d = next_phase(state_q);
                cnt_d   = phase_load(state_d);
                pt_d    = 1'b1;
                if (state_d == RED) walk_d = PED_EN ? req_q : 1'b1;
                if (state_q == RED) req_d = 1'b0;
            end else begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end
        // A press landing on the RED-exit tick survives into the next GREEN.
        if (PED_EN && ped_rise) req_d = 1'b1;
    end

    assign light_r    = (state_q == ALL_RED) || (state_q == RED);
    assign light_g    = (state_q == GREEN);
    assign light_y    = (state_q == YELLOW) && blink_sync;
    assign walk       = (state_q == RED) && walk_q;
    assign remaining  = cnt_q;
    assign phase_tick = pt_q;

endmodule

// File: tb/tb_traffic_phase_sequencer.sv
// Self-checking bench for traffic_phase_sequencer against a tick-level phase schedule model.
module tb_traffic_phase_sequencer;

    localparam int GT = 8, YT = 3, RT = 6, MT = 2, CW = 4;
    localparam int P_AR = 0, P_G = 1, P_Y = 2, P_R = 3;
`ifdef PED_REQUEST_EN
    localparam bit PED = 1'b1;
`else
    localparam bit PED = 1'b0;
`endif

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          tick_in = 1'b0;
    logic          blink_in = 1'b0;
    logic          ped_req = 1'b0;
    logic          light_g, light_y, light_r, walk, phase_tick;
    logic [CW-1:0] remaining;

    int tests = 0;
    int fails = 0;

    int            m_phase, m_el;
    bit            m_latch, m_walk, b_last, blink_rand;
    logic [2:0]    e_lamps;
    logic [CW-1:0] e_rem;
    bit            e_walk, e_tr, e_blink;
    int            pt_seen, tr_seen;

    traffic_phase_sequencer dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .tick_in    (tick_in),
        .blink_in   (blink_in),
        .ped_req    (ped_req),
        .light_g    (light_g),
        .light_y    (light_y),
        .light_r    (light_r),
        .walk       (walk),
        .remaining  (remaining),
        .phase_tick (phase_tick)
    );

    always #5 clock = ~clock;

    function automatic int dur(input int p);
        case (p)
            P_G:     return GT;
            P_Y:     return YT;
            P_R:     return RT;
            default: return 1;
        endcase
    endfunction

    task automatic model_reset();
        m_phase = P_AR; m_el = 0; m_latch = 0; m_walk = 0; b_last = 0;
    endtask

    task automatic model_tick();
        bit cut;
        m_el++;
        cut = PED && (m_phase == P_G) && m_latch && (m_el >= MT);
        if (m_el >= dur(m_phase) || cut) begin
            if (m_phase == P_R) m_latch = 0;
            m_phase = (m_phase == P_R) ? P_G : m_phase + 1;
            m_el = 0;
            e_tr = 1;
            if (m_phase == P_R) m_walk = PED ? m_latch : 1'b1;
        end
    endtask

    // One clock: advance, then refresh the expected outputs for this sample point.
    task automatic cycle(input bit teff, input bit peff);
        bit bs;
        bs = blink_in;
        @(posedge clock); #1;
        e_blink = b_last; b_last = bs; e_tr = 0;
        if (teff) model_tick();
        if (peff && PED) m_latch = 1;
        e_lamps = {(m_phase == P_AR) || (m_phase == P_R), m_phase == P_G, (m_phase == P_Y) && e_blink};
        e_rem   = CW'(dur(m_phase) - 1 - m_el);
        e_walk  = (m_phase == P_R) && m_walk;
        if (e_tr) tr_seen++;
        if (phase_tick === 1'b1) pt_seen++;
        if (blink_rand) blink_in = 1'($urandom_range(0, 1));
    endtask

    // tick_in period 10: high for cycles 0..4; its tick takes effect at cycle 2.
    task automatic drive(input int c, input bit pw, input bit pm);
        case (c)
            0: begin tick_in = 1'b1; if (pw) ped_req = 1'b1; end
            3: if (pw) ped_req = 1'b0;
            5: tick_in = 1'b0;
            6: if (pm) ped_req = 1'b1;
            8: if (pm) ped_req = 1'b0;
            default: ;
        endcase
    endtask

    task automatic run_tick(input bit pw, input bit pm);
        for (int c = 0; c < 10; c++) begin
            drive(c, pw, pm);
            cycle(c == 2, (pw && c == 2) || (pm && c == 8));
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0; tick_in = 1'b0; ped_req = 1'b0;
        repeat (2) @(posedge clock);
        #1 reset_n = 1'b1;
        model_reset();
        repeat (5) cycle(1'b0, 1'b0);
    endtask

    task automatic test_reset();
        reset_n = 1'b0; tick_in = 1'b1; blink_in = 1'b1; blink_rand = 0;
        repeat (3) @(posedge clock);
        #1;
        tests++; if ({light_r, light_g, light_y} !== 3'b100) begin fails++; $display("FAIL reset_lamps got %b want 100", {light_r, light_g, light_y}); end
        tests++; if (remaining !== 4'd0) begin fails++; $display("FAIL reset_remaining got %0d want 0", remaining); end
        tests++; if (walk !== 1'b0) begin fails++; $display("FAIL reset_walk got %b want 0", walk); end
        tests++; if (phase_tick !== 1'b0) begin fails++; $display("FAIL reset_phase_tick got %b want 0", phase_tick); end
        reset_n = 1'b1;
        model_reset();
        for (int c = 0; c < 8; c++) begin
            cycle(1'b0, 1'b0);
            tests++;
            if ({light_r, light_g, light_y, remaining, phase_tick} !== {3'b100, 4'd0, 1'b0}) begin
                fails++; $display("FAIL no_tick_at_release c=%0d got lamps %b rem %0d pt %b want 100/0/0", c, {light_r, light_g, light_y}, remaining, phase_tick);
            end
        end
        tick_in = 1'b0;
        repeat (5) cycle(1'b0, 1'b0);
        run_tick(0, 0);
        tests++; if ({light_r, light_g, light_y, remaining} !== {3'b010, 4'd7}) begin
            fails++; $display("FAIL first_tick got lamps %b rem %0d want 010 rem 7", {light_r, light_g, light_y}, remaining);
        end
    endtask

    task automatic test_free_run();
        logic [2:0] prev;
        int run, runs_done, want;
        blink_rand = 0; blink_in = 1'b1; ped_req = 1'b0;
        prev = {light_r, light_g, light_y}; run = 0; runs_done = 0;
        pt_seen = 0; tr_seen = 0;
        for (int t = 0; t < 40; t++) begin
            for (int c = 0; c < 10; c++) begin
                drive(c, 0, 0);
                cycle(c == 2, 1'b0);
                tests++; if ({light_r, light_g, light_y} !== e_lamps) begin fails++; $display("FAIL free_lamps t=%0d c=%0d got %b want %b", t, c, {light_r, light_g, light_y}, e_lamps); end
                tests++; if (remaining !== e_rem) begin fails++; $display("FAIL free_remaining t=%0d c=%0d got %0d want %0d", t, c, remaining, e_rem); end
                tests++; if (phase_tick !== e_tr) begin fails++; $display("FAIL free_phase_tick t=%0d c=%0d got %b want %b", t, c, phase_tick, e_tr); end
                if ({light_r, light_g, light_y} == prev) run++;
                else begin
                    if (runs_done > 0) begin
                        want = (prev == 3'b010) ? GT * 10 : (prev == 3'b001) ? YT * 10 : RT * 10;
                        tests++; if (run != want) begin fails++; $display("FAIL phase_length lamps %b got %0d cycles want %0d", prev, run, want); end
                    end
                    runs_done++; prev = {light_r, light_g, light_y}; run = 1;
                end
            end
        end
        tests++; if (pt_seen != tr_seen) begin fails++; $display("FAIL phase_tick_count got %0d want %0d", pt_seen, tr_seen); end
    endtask

    task automatic test_random();
        bit pw, pm;
        blink_rand = 1;
        for (int t = 0; t < 60; t++) begin
            pw = ($urandom_range(0, 4) == 0);
            pm = ($urandom_range(0, 3) == 0);
            for (int c = 0; c < 10; c++) begin
                drive(c, pw, pm);
                cycle(c == 2, (pw && c == 2) || (pm && c == 8));
                tests++; if ({light_r, light_g, light_y} !== e_lamps) begin fails++; $display("FAIL rand_lamps t=%0d c=%0d got %b want %b", t, c, {light_r, light_g, light_y}, e_lamps); end
                tests++; if (remaining !== e_rem) begin fails++; $display("FAIL rand_remaining t=%0d c=%0d got %0d want %0d", t, c, remaining, e_rem); end
                tests++; if (walk !== e_walk) begin fails++; $display("FAIL rand_walk t=%0d c=%0d got %b want %b", t, c, walk, e_walk); end
                tests++; if (phase_tick !== e_tr) begin fails++; $display("FAIL rand_phase_tick t=%0d c=%0d got %b want %b", t, c, phase_tick, e_tr); end
            end
        end
        blink_rand = 0; blink_in = 1'b1;
    endtask

`ifdef PED_REQUEST_EN
    task automatic test_ped_cut();
        blink_rand = 0; blink_in = 1'b1;
        do_reset();
        run_tick(0, 0);
        run_tick(0, 1);
        tests++; if ({light_g, remaining} !== {1'b1, 4'd6}) begin fails++; $display("FAIL ped_tick1 got g=%b rem %0d want g=1 rem 6", light_g, remaining); end
        run_tick(0, 0);
        tests++; if ({light_g, light_y, remaining} !== {1'b0, 1'b1, 4'd2}) begin fails++; $display("FAIL ped_cut got g=%b y=%b rem %0d want g=0 y=1 rem 2", light_g, light_y, remaining); end
        repeat (3) run_tick(0, 0);
        for (int t = 0; t < 6; t++) begin
            for (int c = 0; c < 10; c++) begin
                drive(c, 0, 0);
                cycle(c == 2, 1'b0);
                tests++;
                if ({light_r, walk} !== ((t == 5 && c >= 2) ? 2'b00 : 2'b11)) begin
                    fails++; $display("FAIL ped_walk t=%0d c=%0d got r=%b walk=%b", t, c, light_r, walk);
                end
            end
        end
        repeat (2) run_tick(0, 0);
        tests++; if ({light_g, remaining} !== {1'b1, 4'd5}) begin fails++; $display("FAIL ped_latch_cleared got g=%b rem %0d want g=1 rem 5", light_g, remaining); end
    endtask

    task automatic test_ped_coincide();
        blink_rand = 0; blink_in = 1'b1;
        do_reset();
        repeat (3) run_tick(0, 0);
        run_tick(1, 0);
        tests++; if ({light_g, remaining} !== {1'b1, 4'd4}) begin fails++; $display("FAIL coincide_same_tick got g=%b rem %0d want g=1 rem 4", light_g, remaining); end
        run_tick(0, 0);
        tests++; if ({light_y, remaining} !== {1'b1, 4'd2}) begin fails++; $display("FAIL coincide_next_tick got y=%b rem %0d want y=1 rem 2", light_y, remaining); end
    endtask
`else
    task automatic test_ped_ignored();
        blink_rand = 0; blink_in = 1'b1;
        do_reset();
        run_tick(0, 0);
        run_tick(0, 1);
        run_tick(1, 0);
        tests++; if ({light_g, remaining} !== {1'b1, 4'd5}) begin fails++; $display("FAIL ped_ignored got g=%b rem %0d want g=1 rem 5", light_g, remaining); end
        repeat (6) run_tick(0, 0);
        tests++; if ({light_y, remaining} !== {1'b1, 4'd2}) begin fails++; $display("FAIL green_full_length got y=%b rem %0d want y=1 rem 2", light_y, remaining); end
        repeat (3) run_tick(0, 0);
        tests++; if ({light_r, walk, remaining} !== {1'b1, 1'b1, 4'd5}) begin fails++; $display("FAIL walk_in_red got r=%b walk=%b rem %0d want 1 1 5", light_r, walk, remaining); end
    endtask
`endif

    task automatic test_reset_mid_yellow();
        bit found;
        blink_rand = 0; blink_in = 1'b1; ped_req = 1'b0;
        found = 0;
        for (int t = 0; t < 40 && !found; t++) begin
            run_tick(0, 0);
            if (m_phase == P_Y && e_rem == 1) found = 1;
        end
        tests++; if ({light_y, remaining} !== {1'b1, 4'd1}) begin fails++; $display("FAIL mid_yellow_reached got y=%b rem %0d want y=1 rem 1", light_y, remaining); end
        reset_n = 1'b0;
        #2;
        tests++; if ({light_r, light_g, light_y} !== 3'b100) begin fails++; $display("FAIL async_reset_lamps got %b want 100", {light_r, light_g, light_y}); end
        tests++; if (remaining !== 4'd0) begin fails++; $display("FAIL async_reset_remaining got %0d want 0", remaining); end
        @(posedge clock); #1;
        reset_n = 1'b1;
        model_reset();
        repeat (5) cycle(1'b0, 1'b0);
        tests++; if ({light_r, light_g, light_y, remaining} !== {3'b100, 4'd0}) begin fails++; $display("FAIL post_reset_all_red got lamps %b rem %0d", {light_r, light_g, light_y}, remaining); end
        run_tick(0, 0);
        tests++; if ({light_r, light_g, light_y, remaining} !== {3'b010, 4'd7}) begin fails++; $display("FAIL post_reset_green got lamps %b rem %0d want 010 rem 7", {light_r, light_g, light_y}, remaining); end
    endtask

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        model_reset();
        test_reset();
        test_free_run();
        test_random();
`ifdef PED_REQUEST_EN
        test_ped_cut();
        test_ped_coincide();
`else
        test_ped_ignored();
`endif
        test_reset_mid_yellow();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
